mips_divider: RTL and testbench

//   Multi-cycle iterative restoring divider for MIPS DIV/DIVU. It is the inverse

---
 rtl/mips_divider_pkg.sv | 15 +
 rtl/mips_divider_if.sv | 29 ++
 rtl/mips_divider_div_step.sv | 32 +++
 rtl/mips_divider.sv | 132 +++++++++++++
 tb/tb_mips_divider.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_divider_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU divider.
//   DIV_WIDTH   : default operand/result width
//   div_state_t : divider sequencing states
package mips_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/mips_divider_if.sv
// Request/response bundle between the EX stage and the divider.
//   master : EX side, drives start/is_signed/dividend/divisor and
//            observes busy/done/quotient/remainder/div_by_zero
//   slave  : divider side, the mirror image of master
interface mips_divider_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/mips_divider_div_step.sv
// One combinational restoring-division step.
//   rem         : current partial remainder
//   quo_msb     : dividend bit shifted into the remainder this step
//   divisor_mag : unsigned divisor magnitude
//   next_rem    : partial remainder after the trial subtraction
//   q_bit       : quotient bit produced by this step
module mips_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_bits;

  // The shifted remainder can need WIDTH+1 bits, so one extra borrow bit
  // is kept to tell whether the trial subtraction went negative.
  assign shifted  = {rem, quo_msb};
  assign trial    = {1'b0, shifted} - {2'b00, divisor_mag};
  assign q_bit    = ~trial[WIDTH+1];
  assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

  // When the subtraction succeeds the result is below the divisor, so the
  // top bits carry no information and are intentionally dropped.
  assign unused_bits = ^{trial[WIDTH], shifted[WIDTH]};

endmodule

// File: rtl/mips_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of mips_divider_if (request operands, busy/done,
//         quotient to LO, remainder to HI, div_by_zero flag)
// Latency is fixed: done pulses WIDTH+1 edges after the accepting edge.
module mips_divider
  import mips_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic           clk,
  input logic           rst,
  mips_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state;
  div_state_t       next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] dividend_raw;
  logic             sign_q;
  logic             sign_r;
  logic             div_zero;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_by_zero_reg;
  logic             done_reg;

  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag_in;
  logic [WIDTH-1:0] divisor_mag_in;
  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

  // Magnitudes are taken only for signed requests; -2^(W-1) negates to
  // itself, which is exactly its unsigned magnitude.
  assign dividend_neg    = bus.is_signed & bus.dividend[WIDTH-1];
  assign divisor_neg     = bus.is_signed & bus.divisor[WIDTH-1];
  assign dividend_mag_in = dividend_neg ? -bus.dividend : bus.dividend;
  assign divisor_mag_in  = divisor_neg  ? -bus.divisor  : bus.divisor;

  mips_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem),
    .quo_msb     (quo[WIDTH-1]),
    .divisor_mag (divisor_mag),
    .next_rem    (step_rem),
    .q_bit       (step_q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; RUN lasts exactly WIDTH edges.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) next_state = FIXUP;
      FIXUP:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and sign fixup into the
  // output registers. Outputs hold until the next completed division.
  always_ff @(posedge clk) begin
    if (rst) begin
      count           <= '0;
      rem             <= '0;
      quo             <= '0;
      divisor_mag     <= '0;
      dividend_raw    <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      div_zero        <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            quo          <= dividend_mag_in;
            divisor_mag  <= divisor_mag_in;
            dividend_raw <= bus.dividend;
            sign_q       <= dividend_neg ^ divisor_neg;
            sign_r       <= dividend_neg;
            div_zero     <= (bus.divisor == '0);
            rem          <= '0;
            count        <= '0;
          end
        end
        RUN: begin
          rem   <= step_rem;
          quo   <= {quo[WIDTH-2:0], step_q_bit};
          count <= count + 1'b1;
        end
        FIXUP: begin
          if (div_zero) begin
            quotient_reg  <= '1;
            remainder_reg <= dividend_raw;
          end else begin
            quotient_reg  <= sign_q ? -quo : quo;
            remainder_reg <= sign_r ? -rem : rem;
          end
          div_by_zero_reg <= div_zero;
          done_reg        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_mips_divider.sv
// Self-checking bench for mips_divider: stimulus pushes expected results
// from an arithmetic reference model into a scoreboard queue; a monitor
// pops and compares whenever done is seen.
module tb_mips_divider;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           start_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total_checks = 0;
  int   pass_checks  = 0;
  exp_t sb_q[$];

  mips_divider_if #(.WIDTH(W)) bus();

  mips_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and edge counter used for latency measurement.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and reports failures.
  function automatic void check_output(input string name, input logic [W-1:0] act,
                                       input logic [W-1:0] exp);
    total_checks++;
    if (act === exp) pass_checks++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // Reference model straight from the arithmetic definition of DIV/DIVU.
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    e.start_cyc = 0;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      e.q   = W'(sa / sb);
      e.r   = W'(sa % sb);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Drive one request from a negedge; if expected, queue the model result
  // stamped with the accepting edge.
  task automatic apply_stimulus(input logic sgn, input logic [W-1:0] a,
                                input logic [W-1:0] b, input bit expect_it);
    exp_t e;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    if (expect_it) begin
      e = model(sgn, a, b);
      e.start_cyc = cyc;
      sb_q.push_back(e);
    end
  endtask

  // Bounded wait until the divider returns to idle.
  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      total_checks++;
      $display("[TB] FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, "_busy"}, W'(bus.busy), '0);
    check_output({tag, "_done"}, W'(bus.done), '0);
    check_output({tag, "_quotient"}, bus.quotient, '0);
    check_output({tag, "_remainder"}, bus.remainder, '0);
    check_output({tag, "_dbz"}, W'(bus.div_by_zero), '0);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sb_q.size() == 0) begin
        total_checks++;
        $display("[TB] FAIL unexpected_done: got done with q=0x%08h, expected no result",
                 bus.quotient);
      end else begin
        e = sb_q.pop_front();
        check_output("quotient", bus.quotient, e.q);
        check_output("remainder", bus.remainder, e.r);
        check_output("div_by_zero", W'(bus.div_by_zero), W'(e.dbz));
        check_output("latency", W'(cyc - e.start_cyc), W'(LATENCY));
      end
    end
  end

  initial begin
    int n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    apply_stimulus(1'b0, 32'd100, 32'd7, 1'b1);             wait_idle();
    apply_stimulus(1'b1, 32'hFFFF_FFF9, 32'h2, 1'b1);       wait_idle();
    apply_stimulus(1'b1, 32'h7, 32'hFFFF_FFFE, 1'b1);       wait_idle();
    apply_stimulus(1'b0, 32'd5, 32'd0, 1'b1);               wait_idle();
    apply_stimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
    apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1);       wait_idle();
    apply_stimulus(1'b1, 32'hFFFF_FFF7, 32'h0, 1'b1);       wait_idle();
    apply_stimulus(1'b1, 32'h8000_0000, 32'h7, 1'b1);       wait_idle();

    // A start pulse mid-RUN with different operands must be ignored.
    apply_stimulus(1'b0, 32'd1000, 32'd10, 1'b1);
    repeat (5) @(negedge clk);
    bus.dividend  = 32'd3;
    bus.divisor   = 32'd1;
    bus.is_signed = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Start raised during the DONE cycle is ignored; held into the next
    // (idle) cycle it is accepted.
    apply_stimulus(1'b0, 32'd50, 32'd5, 1'b1);
    n = 0;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      total_checks++;
      $display("[TB] FAIL done_timeout: done never seen after %0d cycles", n);
    end
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd77;
    bus.divisor   = 32'd7;
    bus.start     = 1'b1;
    @(negedge clk);
    check_output("start_in_done_ignored", W'(bus.busy), '0);
    apply_stimulus(1'b0, 32'd77, 32'd7, 1'b1);
    wait_idle();

    // Reset part-way through RUN clears everything and suppresses done.
    apply_stimulus(1'b0, 32'd12345, 32'd67, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("midrun_reset");
    rst = 1'b0;
    @(negedge clk);
    apply_stimulus(1'b0, 32'd9, 32'd3, 1'b1);
    wait_idle();

    // Randomized mix of signed/unsigned, small, large and zero divisors.
    for (int i = 0; i < 60; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        4:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      apply_stimulus(sgn, a, b, 1'b1);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total_checks++;
      $display("[TB] FAIL missing_results: %0d results outstanding, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
